// File: rtl/hazard_pkg.sv
// Shared types and encodings for the execute-stage hazard controller.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [1:0]        fwd_sel_t;

  // Operand mux selects on the execute-stage A/B inputs
  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_WB  = 2'b01;
  localparam fwd_sel_t FWD_MEM = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_e;

  // Memory-stage producer wins over writeback; x0 is never forwarded.
  function automatic fwd_sel_t fwd_select(input reg_addr_t rs,
                                          input reg_addr_t rd_m,
                                          input logic      we_m,
                                          input reg_addr_t rd_w,
                                          input logic      we_w);
    fwd_sel_t sel;
    sel = FWD_RF;
    if (we_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (we_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Clear first, otherwise step up until all ones
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, zeroed while reset is low
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_controller.sv
// Execute-stage hazard controller: operand forwarding, load-use and
// taken-branch resolution, multi-cycle op sequencing and debug counters.
//
// state | meaning
// IDLE  | no multi-cycle op in flight; start cycle is handled here
// BUSY  | multi-cycle op holding execute; cnt_q = cycles left incl. this one
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1_D,
  input  logic [REG_AW-1:0] Rs2_D,
  input  logic [REG_AW-1:0] Rs1_E,
  input  logic [REG_AW-1:0] Rs2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic              ResultSrcE,
  input  logic              PCSrcE,
  input  logic              MulStartE,
  input  logic [REG_AW-1:0] RD_M,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] RD_W,
  input  logic              RegWriteW,
  input  logic              CntClr,
  output logic [1:0]        ForwardA_E,
  output logic [1:0]        ForwardB_E,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              MulBusy,
  output logic              MulDoneE,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);
  localparam bit         MULTI    = (MUL_LATENCY > 1);

  mul_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       mul_stall, mul_done;
  logic       branch, lw_stall, lw_take;

  // FSM state and countdown registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and multi-cycle hold/done decode; a taken branch cancels a start
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mul_stall = 1'b0;
    mul_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (MulStartE && !PCSrcE) begin
          if (MULTI) begin
            mul_stall = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = BUSY;
          end else begin
            mul_done = 1'b1;
          end
        end
      end
      BUSY: begin
        if (cnt_q > 4'd1) begin
          mul_stall = 1'b1;
          cnt_d     = cnt_q - 4'd1;
        end else begin
          mul_done = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Branches are ignored while execute holds a multi-cycle op
  assign branch   = (state_q == IDLE) && PCSrcE;
  assign lw_stall = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));
  assign lw_take  = lw_stall && !mul_stall && !branch;

  // Pipeline controls; everything reads 0 while reset is held
  always_comb begin
    ForwardA_E = FWD_RF;
    ForwardB_E = FWD_RF;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushM     = 1'b0;
    MulBusy    = 1'b0;
    MulDoneE   = 1'b0;
    if (rst) begin
      ForwardA_E = fwd_select(Rs1_E, RD_M, RegWriteM, RD_W, RegWriteW);
      ForwardB_E = fwd_select(Rs2_E, RD_M, RegWriteM, RD_W, RegWriteW);
      StallF     = mul_stall || lw_take;
      StallD     = mul_stall || lw_take;
      StallE     = mul_stall;
      FlushD     = branch;
      FlushE     = branch || lw_take;
      FlushM     = mul_stall;
      MulBusy    = (state_q == BUSY);
      MulDoneE   = mul_done;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (CntClr),
    .inc   (StallF),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (CntClr),
    .inc   (FlushE),
    .count (FlushCount)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: per-cycle reference model plus directed vectors.
module tb_hazard_controller;

  localparam int LAT   = 4;
  localparam int CNT_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
  logic       ResultSrcE, PCSrcE, MulStartE, RegWriteM, RegWriteW, CntClr;
  logic [1:0] ForwardA_E, ForwardB_E;
  logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE;
  logic [CNT_W-1:0] StallCount, FlushCount;

  int checks = 0;
  int errors = 0;

  hazard_controller #(.MUL_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .RD_E(RD_E),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MulStartE(MulStartE),
    .RD_M(RD_M), .RegWriteM(RegWriteM), .RD_W(RD_W), .RegWriteW(RegWriteW),
    .CntClr(CntClr),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .MulBusy(MulBusy), .MulDoneE(MulDoneE),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_left  = 0;   // cycles of the multi-cycle op still to run after this one
  int m_stall = 0;
  int m_flush = 0;

  function automatic int fwd_ref(input logic [4:0] rs);
    if (RegWriteM && RD_M != 0 && RD_M == rs) return 2;
    if (RegWriteW && RD_W != 0 && RD_W == rs) return 1;
    return 0;
  endfunction

  // Compare on the falling edge, then advance the model to the next cycle
  always @(negedge clk) begin
    int  rem;
    bit  busy, mstall, mdone, br, lw, lwt;
    bit  eF, eE, eFD, eFE, eFM;
    if (!rst) begin
      chk("rst_fwdA", ForwardA_E, 0);
      chk("rst_fwdB", ForwardB_E, 0);
      chk("rst_ctl", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulBusy, MulDoneE}, 0);
      chk("rst_scnt", StallCount, 0);
      chk("rst_fcnt", FlushCount, 0);
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      busy = (m_left > 0);
      rem  = 0;
      if (busy) rem = m_left;
      else if (MulStartE && !PCSrcE) rem = LAT;
      mstall = (rem > 1);
      mdone  = (rem == 1);
      br     = !busy && PCSrcE;
      lw     = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
      lwt    = lw && !mstall && !br;
      eF  = mstall || lwt;
      eE  = mstall;
      eFD = br;
      eFE = br || lwt;
      eFM = mstall;
      chk("m_fwdA", ForwardA_E, fwd_ref(Rs1_E));
      chk("m_fwdB", ForwardB_E, fwd_ref(Rs2_E));
      chk("m_StallF", StallF, eF);
      chk("m_StallD", StallD, eF);
      chk("m_StallE", StallE, eE);
      chk("m_FlushD", FlushD, eFD);
      chk("m_FlushE", FlushE, eFE);
      chk("m_FlushM", FlushM, eFM);
      chk("m_MulBusy", MulBusy, busy);
      chk("m_MulDone", MulDoneE, mdone);
      chk("m_scnt", StallCount, m_stall);
      chk("m_fcnt", FlushCount, m_flush);
      m_left = (rem > 0) ? rem - 1 : 0;
      if (CntClr) begin
        m_stall = 0;
        m_flush = 0;
      end else begin
        if (eF  && m_stall < CMAX) m_stall++;
        if (eFE && m_flush < CMAX) m_flush++;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
    ResultSrcE = 0; PCSrcE = 0; MulStartE = 0; RegWriteM = 0; RegWriteW = 0;
    CntClr = 0;
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    // Busy inputs during reset must still give all-zero outputs
    Rs1_E = 3; RD_M = 3; RegWriteM = 1; PCSrcE = 1; ResultSrcE = 1; RD_E = 2; Rs1_D = 2;
    #2;
    chk("d_rst_fwdA", ForwardA_E, 0);
    chk("d_rst_flushD", FlushD, 0);
    chk("d_rst_stallF", StallF, 0);
    step();
    step();
    quiet();
    rst = 1'b1;
    step();

    // Forwarding: memory over writeback, then writeback, x0 never forwarded
    RD_M = 3; RegWriteM = 1; RD_W = 3; RegWriteW = 1; Rs1_E = 3; Rs2_E = 0;
    #1;
    chk("d_fwdA_mem", ForwardA_E, 2);
    chk("d_fwdB_x0", ForwardB_E, 0);
    step();
    RD_M = 0;
    #1;
    chk("d_fwdA_wb", ForwardA_E, 1);
    step();
    quiet();

    // Load-use for one cycle
    ResultSrcE = 1; RD_E = 5; Rs2_D = 5;
    #1;
    chk("d_lw_stallF", StallF, 1);
    chk("d_lw_stallD", StallD, 1);
    chk("d_lw_flushE", FlushE, 1);
    chk("d_lw_stallE", StallE, 0);
    chk("d_lw_cnt0", StallCount, 0);
    step();
    quiet();
    #1;
    chk("d_lw_cnt1", StallCount, 1);

    // Branch together with load-use: branch wins
    ResultSrcE = 1; RD_E = 5; Rs1_D = 5; PCSrcE = 1;
    #1;
    chk("d_br_flushD", FlushD, 1);
    chk("d_br_flushE", FlushE, 1);
    chk("d_br_stallF", StallF, 0);
    chk("d_br_stallD", StallD, 0);
    step();
    quiet();
    #1;
    chk("d_br_scnt", StallCount, 1);
    chk("d_br_fcnt", FlushCount, 2);

    // Clear counters, then a held multi-cycle op
    CntClr = 1;
    step();
    CntClr = 0;
    #1;
    chk("d_clr_scnt", StallCount, 0);
    MulStartE = 1;
    for (int c = 1; c <= LAT; c++) begin
      if (c == 2) PCSrcE = 1;                                   // ignored in BUSY
      if (c == 3) begin ResultSrcE = 1; RD_E = 7; Rs1_D = 7; end // overridden
      #1;
      if (c < LAT) begin
        chk("d_mul_stallF", StallF, 1);
        chk("d_mul_stallE", StallE, 1);
        chk("d_mul_flushM", FlushM, 1);
        chk("d_mul_flushE", FlushE, 0);
        chk("d_mul_flushD", FlushD, 0);
        chk("d_mul_done0", MulDoneE, 0);
      end else begin
        chk("d_mul_done", MulDoneE, 1);
        chk("d_mul_last_stall", StallF, 0);
      end
      step();
      PCSrcE = 0; ResultSrcE = 0; RD_E = 0; Rs1_D = 0;
    end
    MulStartE = 0;
    #1;
    chk("d_mul_idle", MulBusy, 0);
    chk("d_mul_scnt", StallCount, 3);
    chk("d_mul_fcnt", FlushCount, 0);

    // Branch and start in the same IDLE cycle: no op starts
    PCSrcE = 1; MulStartE = 1;
    #1;
    chk("d_brmul_flushD", FlushD, 1);
    chk("d_brmul_stallE", StallE, 0);
    step();
    quiet();
    #1;
    chk("d_brmul_busy", MulBusy, 0);

    // Reset during the first BUSY cycle aborts the op
    MulStartE = 1;
    step();
    #1;
    chk("d_abort_busy_pre", MulBusy, 1);
    rst = 1'b0;
    MulStartE = 0;
    #1;
    chk("d_abort_busy", MulBusy, 0);
    chk("d_abort_stall", StallF, 0);
    chk("d_abort_scnt", StallCount, 0);
    step();
    rst = 1'b1;
    for (int c = 0; c < LAT; c++) begin
      step();
      chk("d_abort_nodone", MulDoneE, 0);
    end

    // Saturation over a long forced load-use stall
    ResultSrcE = 1; RD_E = 9; Rs1_D = 9;
    repeat (65540) step();
    chk("d_sat_scnt", StallCount, 16'hFFFF);
    repeat (2) step();
    chk("d_sat_hold", StallCount, 16'hFFFF);
    chk("d_sat_fcnt", FlushCount, 16'hFFFF);
    CntClr = 1;
    ResultSrcE = 0;
    step();
    CntClr = 0;
    #1;
    chk("d_sat_clr", StallCount, 0);
    step();
    chk("d_sat_clr_hold", StallCount, 0);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
